// File: rtl/lcd_scan_out.sv
// lcd_scan_out: streams a 64-pixel (8x8) frame from image RAM to a panel in raster order
// with valid/ready handshaking and optional blank cycles between rows.
module lcd_scan_out #(
   parameter int H_BLANK = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       RAM_rd,
   output logic [5:0] RAM_A,
   input  logic [7:0] RAM_Q,
   output logic       pix_valid,
   input  logic       pix_ready,
   output logic [7:0] pix_data,
   output logic       pix_sof,
   output logic       pix_eol,
   output logic       busy,
   output logic       frame_done
);
   localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, WAIT = 3'd2, SEND = 3'd3, HBLANK = 3'd4, FIN = 3'd5;
   logic [2:0] state, row, col;
   logic [3:0] hcnt;
   logic sof, eol;
   // RAM_A only changes on entry to FETCH, so it holds the last issued address otherwise
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         row <= 3'd0;
         col <= 3'd0;
         hcnt <= 4'd0;
         RAM_A <= 6'd0;
         pix_data <= 8'd0;
         sof <= 1'b0;
         eol <= 1'b0;
      end else
         case (state)
            IDLE: if (start) begin
               row <= 3'd0;
               col <= 3'd0;
               RAM_A <= 6'd0;
               state <= FETCH;
            end
            FETCH: state <= WAIT;
            WAIT: begin
               pix_data <= RAM_Q;
               sof <= (row == 3'd0) && (col == 3'd0);
               eol <= col == 3'd7;
               state <= SEND;
            end
            SEND: if (pix_ready) begin
               col <= col + 3'd1;
               if (col != 3'd7) begin
                  RAM_A <= {row, col + 3'd1};
                  state <= FETCH;
               end else if (row != 3'd7) begin
                  row <= row + 3'd1;
                  if (H_BLANK == 0) begin
                     RAM_A <= {row + 3'd1, 3'd0};
                     state <= FETCH;
                  end else begin
                     hcnt <= 4'(H_BLANK - 1);
                     state <= HBLANK;
                  end
               end else begin
                  row <= 3'd0;
                  state <= FIN;
               end
            end
            HBLANK: if (hcnt == 4'd0) begin
               RAM_A <= {row, col};
               state <= FETCH;
            end else
               hcnt <= hcnt - 4'd1;
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
   assign RAM_rd = state == FETCH;
   assign pix_valid = state == SEND;
   assign pix_sof = sof & pix_valid;
   assign pix_eol = eol & pix_valid;
   assign busy = state != IDLE;
   assign frame_done = state == FIN;
endmodule

// File: tb/tb_lcd_scan_out.sv
// tb_lcd_scan_out: scoreboard bench; stimulus queues expected pixels/addresses, negedge monitors check them.
module tb_lcd_scan_out;
   logic clk, reset, start, pix_ready;
   logic RAM_rd, pix_valid, pix_sof, pix_eol, busy, frame_done;
   logic [5:0] RAM_A;
   logic [7:0] RAM_Q, pix_data;
   logic start0, RAM_rd0, pix_valid0, pix_sof0, pix_eol0, busy0, frame_done0;
   logic [5:0] RAM_A0;
   logic [7:0] RAM_Q0, pix_data0;
   int tests = 0, fails = 0, cyc = 0, fd_cnt = 0, t0 = 0;
   logic [9:0] q[$];
   logic [5:0] aq[$];
   logic [7:0] q0[$];
   logic eol_prev0 = 1'b0;

   lcd_scan_out #(.H_BLANK(2)) dut (
      .clk(clk), .reset(reset), .start(start), .RAM_rd(RAM_rd), .RAM_A(RAM_A), .RAM_Q(RAM_Q),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
      .pix_eol(pix_eol), .busy(busy), .frame_done(frame_done));

   lcd_scan_out #(.H_BLANK(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .RAM_rd(RAM_rd0), .RAM_A(RAM_A0), .RAM_Q(RAM_Q0),
      .pix_valid(pix_valid0), .pix_ready(1'b1), .pix_data(pix_data0), .pix_sof(pix_sof0),
      .pix_eol(pix_eol0), .busy(busy0), .frame_done(frame_done0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // image RAM holds RAM[i] = i, one-cycle read latency
   always @(posedge clk) begin
      if (RAM_rd) RAM_Q <= {2'b00, RAM_A};
      if (RAM_rd0) RAM_Q0 <= {2'b00, RAM_A0};
      cyc <= cyc + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [9:0] e;
      if (frame_done) fd_cnt++;
      if (RAM_rd) begin
         check("addr_expected", int'(aq.size() != 0), 1);
         if (aq.size() != 0) check("addr", RAM_A, aq.pop_front());
      end
      if (pix_valid && pix_ready) begin
         check("pix_expected", int'(q.size() != 0), 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("pix_data", pix_data, e[9:2]);
            check("pix_sof", pix_sof, e[1]);
            check("pix_eol", pix_eol, e[0]);
         end
      end
   end

   always @(negedge clk) begin
      if (eol_prev0) check("h0_fetch_after_eol", RAM_rd0, 1);
      if (pix_valid0) begin
         check("h0_expected", int'(q0.size() != 0), 1);
         if (q0.size() != 0) check("h0_pix_data", pix_data0, q0.pop_front());
         check("h0_sof", pix_sof0, int'(pix_data0 == 8'd0));
      end
      eol_prev0 = pix_valid0 && pix_eol0 && pix_data0 != 8'd63;
   end

   task automatic push_frame();
      for (int i = 0; i < 64; i++) begin
         q.push_back({8'(i), i == 0, i % 8 == 7});
         aq.push_back(6'(i));
      end
   endtask

   task automatic start_frame();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_fetch(input int a);
      for (int i = 0; i < 1000; i++) begin
         if (RAM_rd && RAM_A == 6'(a)) break;
         @(posedge clk); #1;
      end
      check("fetch_found", int'(RAM_rd && RAM_A == 6'(a)), 1);
   endtask

   task automatic wait_done(input int exp, input bit poke);
      for (int i = 0; i < 3000 && !frame_done; i++) begin
         start = poke && (i == 40 || i == 100);
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("done_seen", frame_done, 1);
      check("frame_cycles", cyc - t0 + 1, exp);
      start = poke;
      @(posedge clk); #1;
      start = 1'b0;
      check("idle_busy", busy, 0);
      check("done_one_cycle", frame_done, 0);
      check("all_pixels_out", q.size(), 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_rd", RAM_rd, 0);
      check("rst_addr", RAM_A, 0);
      check("rst_valid", pix_valid, 0);
      check("rst_data", pix_data, 0);
      check("rst_sof", pix_sof, 0);
      check("rst_eol", pix_eol, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start0 = 1'b0; pix_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle_after_reset", busy, 0);
      // nominal frame, H_BLANK=2
      push_frame();
      start_frame();
      check("first_fetch_rd", RAM_rd, 1);
      check("first_fetch_addr", RAM_A, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("first_valid_cycle3", pix_valid, 1);
      check("first_sof", pix_sof, 1);
      wait_done(207, 1'b0);
      // backpressure on pixel 10
      push_frame();
      start_frame();
      wait_fetch(10);
      pix_ready = 1'b0;
      @(posedge clk); #1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         check("stall_valid", pix_valid, 1);
         check("stall_data", pix_data, 10);
         check("stall_no_rd", RAM_rd, 0);
         if (k == 6) pix_ready = 1'b1;
      end
      wait_done(212, 1'b0);
      // start right after FIN is accepted; starts while busy and in FIN are ignored
      push_frame();
      start_frame();
      wait_done(207, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check("frames_done_count", fd_cnt, 3);
      check("still_idle", busy, 0);
      // reset in SEND at row 3, col 4
      push_frame();
      start_frame();
      wait_fetch(28);
      pix_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_valid", pix_valid, 1);
      check("mid_data", pix_data, 28);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_outputs();
      q.delete();
      aq.delete();
      pix_ready = 1'b1;
      @(posedge clk); #1;
      check("post_reset_idle", busy, 0);
      push_frame();
      start_frame();
      wait_done(207, 1'b0);
      // reset wins over start
      reset = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      check("rs_busy", busy, 0);
      check("rs_rd", RAM_rd, 0);
      reset = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      check("rs_stays_idle", busy, 0);
      // H_BLANK=0 instance
      for (int i = 0; i < 64; i++) q0.push_back(8'(i));
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      t0 = cyc;
      for (int i = 0; i < 3000 && !frame_done0; i++) begin
         @(posedge clk); #1;
      end
      check("h0_done_seen", frame_done0, 1);
      check("h0_frame_cycles", cyc - t0 + 1, 193);
      @(posedge clk); #1;
      check("h0_idle", busy0, 0);
      check("h0_all_pixels", q0.size(), 0);
      check("frames_done_total", fd_cnt, 4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
